// File: rtl/btn_pkg.sv
// btn_pkg: shared types and timing helpers for button decoders.
// Imported by every button pin decoder in the project.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      LONG_HELD
   } btn_state_t;

   localparam int SIM_DEB  = 16;
   localparam int SIM_LONG = 256;

   function automatic int cycles_from_us(input int clk_hz, input int us);
      return (clk_hz / 1_000_000) * us;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for one asynchronous pin.
// Both flops clear to 0 on reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops give metastability time to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: sync, debounce and event FSM for one pin.
// Emits a registered level plus press, release and long-press pulses.
module button_event_decoder
   import btn_pkg::*;
#(
   parameter int CLK_HZ        = 50_000_000,
   parameter int DEBOUNCE_US   = 10_000,
   parameter int LONG_PRESS_MS = 1_000,
   parameter bit ACTIVE_HIGH   = 1'b1,
   parameter bit simulation    = 1'b0
) (
   input  logic clk_50MHz,
   input  logic rst_n_i,
   input  logic button_i,
   output logic pressed_o,
   output logic press_o,
   output logic release_o,
   output logic long_press_o
);

   localparam int DEB = simulation ? SIM_DEB
                      : cycles_from_us(CLK_HZ, DEBOUNCE_US);
   localparam int LONG = simulation ? SIM_LONG
                       : (CLK_HZ / 1_000) * LONG_PRESS_MS;
   localparam int DW = $clog2(DEB + 1);
   localparam int HW = $clog2(LONG + 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB - 1);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG - 1);

   generate
      if (DEB < 2) begin : g_deb_chk
         $error("debounce count must be at least 2");
      end
      if (LONG < 2) begin : g_long_chk
         $error("long-press count must be at least 2");
      end
   endgenerate

   logic            sync_q;
   logic            s;
   logic            differ;
   logic            accept;
   logic            press_acc;
   logic            release_acc;
   logic [DW-1:0]   dcnt;
   logic [HW-1:0]   hcnt;
   logic [HW-1:0]   hcnt_d;
   btn_state_t      state;
   btn_state_t      state_d;
   logic            pressed_d;
   logic            press_d;
   logic            release_d;
   logic            long_d;

   sync_2ff u_sync (
      .clk   (clk_50MHz),
      .rst_n (rst_n_i),
      .d     (button_i),
      .q     (sync_q)
   );

   // Registered polarity fix so s is always 1 for a pressed pin.
   always_ff @(posedge clk_50MHz or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s <= 1'b0;
      end else begin
         s <= ACTIVE_HIGH ? sync_q : ~sync_q;
      end
   end

   assign differ      = (s != pressed_o);
   assign accept      = differ && (dcnt == DEB_LAST);
   assign press_acc   = accept && !pressed_o;
   assign release_acc = accept && pressed_o;

   // Any bounce back to the current level restarts the stable count.
   always_ff @(posedge clk_50MHz or negedge rst_n_i) begin
      if (!rst_n_i) begin
         dcnt <= '0;
      end else if (!differ || accept) begin
         dcnt <= '0;
      end else begin
         dcnt <= dcnt + 1'b1;
      end
   end

   // State, hold counter and all outputs; reset drops them silently.
   always_ff @(posedge clk_50MHz or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= IDLE;
         hcnt         <= '0;
         pressed_o    <= 1'b0;
         press_o      <= 1'b0;
         release_o    <= 1'b0;
         long_press_o <= 1'b0;
      end else begin
         state        <= state_d;
         hcnt         <= hcnt_d;
         pressed_o    <= pressed_d;
         press_o      <= press_d;
         release_o    <= release_d;
         long_press_o <= long_d;
      end
   end

   // Next state and event pulses; a release beats the hold threshold.
   always_comb begin
      state_d   = state;
      hcnt_d    = hcnt;
      pressed_d = pressed_o;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      unique case (state)
         IDLE: begin
            if (press_acc) begin
               state_d   = PRESSED;
               hcnt_d    = '0;
               pressed_d = 1'b1;
               press_d   = 1'b1;
            end
         end
         PRESSED: begin
            if (release_acc) begin
               state_d   = IDLE;
               pressed_d = 1'b0;
               release_d = 1'b1;
            end else if (hcnt == LONG_LAST) begin
               state_d = LONG_HELD;
               long_d  = 1'b1;
            end else begin
               hcnt_d = hcnt + 1'b1;
            end
         end
         LONG_HELD: begin
            if (release_acc) begin
               state_d   = IDLE;
               pressed_d = 1'b0;
               release_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: scoreboard bench for button_event_decoder.
// Model flips its level when the last DEB synchronised samples disagree.
module tb_button_event_decoder;

   localparam int DEB  = 16;
   localparam int LONG = 256;
   localparam int LAT  = DEB + 2;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic button = 1'b0;
   logic pressed;
   logic press;
   logic rel;
   logic lng;

   ev_t exp_q[$];
   bit  hist[$];
   bit  lvl;
   bit  long_done;
   int  press_cyc;
   int  cyc;
   int  tests;
   int  fails;
   int  n_press;
   int  n_rel;
   int  n_long;
   int  last_press;
   int  last_rel;
   int  last_long;

   button_event_decoder #(
      .CLK_HZ        (50_000_000),
      .DEBOUNCE_US   (10_000),
      .LONG_PRESS_MS (1_000),
      .ACTIVE_HIGH   (1'b1),
      .simulation    (1'b1)
   ) dut (
      .clk_50MHz    (clk),
      .rst_n_i      (rst_n),
      .button_i     (button),
      .pressed_o    (pressed),
      .press_o      (press),
      .release_o    (rel),
      .long_press_o (lng)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic drive(input logic v, input int n);
      button = v;
      repeat (n) @(negedge clk);
   endtask

   // Reference model: window of pin samples, press time, hold deadline.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl       = 1'b0;
         long_done = 1'b1;
         exp_q.delete();
         hist.delete();
         for (int i = 0; i < DEB + 3; i++) hist.push_back(1'b0);
      end else begin
         bit  all_diff;
         ev_t e;
         cyc++;
         hist.push_back(button);
         void'(hist.pop_front());
         all_diff = 1'b1;
         for (int i = 0; i < DEB; i++)
            if (hist[i] == lvl) all_diff = 1'b0;
         if (all_diff) begin
            lvl    = !lvl;
            e.kind = lvl ? 0 : 1;
            e.cyc  = cyc;
            exp_q.push_back(e);
            if (lvl) begin
               press_cyc = cyc;
               long_done = 1'b0;
            end
         end else if (lvl && !long_done && cyc == press_cyc + LONG) begin
            e.kind = 2;
            e.cyc  = cyc;
            exp_q.push_back(e);
            long_done = 1'b1;
         end
      end
   end

   // Monitor: compare level every cycle and pop on every event pulse.
   always @(negedge clk) begin : mon
      int  nact;
      int  k;
      ev_t e;
      chk("pressed_level", int'(pressed), int'(lvl));
      nact = int'(press) + int'(rel) + int'(lng);
      chk("event_exclusive", int'(nact <= 1), 1);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         tests++;
         fails++;
         $display("FAIL missed_event: kind %0d was due at cycle %0d",
                  exp_q[0].kind, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      if (nact > 0) begin
         k = press ? 0 : (rel ? 1 : 2);
         if (k == 0) begin
            n_press++;
            last_press = cyc;
         end else if (k == 1) begin
            n_rel++;
            last_rel = cyc;
         end else begin
            n_long++;
            last_long = cyc;
         end
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, none due",
                     k, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("event_kind", k, e.kind);
            chk("event_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      int t0;
      int t1;
      int np;
      int nr;
      int nl;

      rst_n  = 1'b0;
      button = 1'b1;
      repeat (4) @(negedge clk);
      chk("reset_outputs", int'({pressed, press, rel, lng}), 0);
      rst_n = 1'b1;
      t0 = cyc + 1;
      repeat (30) @(negedge clk);
      chk("reset_press_latency", last_press - t0, LAT);
      chk("reset_pressed", int'(pressed), 1);
      drive(1'b0, 30);

      nl = n_long;
      t0 = cyc + 1;
      drive(1'b1, 25);
      t1 = cyc + 1;
      drive(1'b0, 30);
      chk("clean_press_latency", last_press - t0, LAT);
      chk("clean_release_latency", last_rel - t1, LAT);
      chk("clean_no_long", n_long, nl);

      np = n_press;
      for (int i = 0; i < 12; i++) drive(1'(i % 2 == 0), 5);
      t0 = cyc + 1;
      drive(1'b1, 40);
      chk("bounce_one_press", n_press - np, 1);
      chk("bounce_latency", last_press - t0, LAT);
      drive(1'b0, 30);

      np = n_press;
      nr = n_rel;
      drive(1'b1, 15);
      drive(1'b0, 30);
      chk("glitch15_no_press", n_press - np, 0);
      chk("glitch15_no_release", n_rel - nr, 0);
      chk("glitch15_level", int'(pressed), 0);
      t0 = cyc + 1;
      drive(1'b1, 16);
      drive(1'b0, 30);
      chk("glitch16_press", n_press - np, 1);
      chk("glitch16_latency", last_press - t0, LAT);

      nl = n_long;
      drive(1'b1, 300);
      t1 = cyc + 1;
      drive(1'b0, 30);
      chk("long_once", n_long - nl, 1);
      chk("long_latency", last_long - last_press, LONG);
      chk("long_release_latency", last_rel - t1, LAT);

      nl = n_long;
      t0 = cyc + 1;
      drive(1'b1, 256);
      drive(1'b0, 30);
      chk("collision_no_long", n_long - nl, 0);
      chk("collision_release_cycle", last_rel - t0, LAT + LONG);

      drive(1'b1, 290);
      nr = n_rel;
      #3 rst_n = 1'b0;
      #1 chk("midreset_outputs", int'({pressed, press, rel, lng}), 0);
      repeat (3) @(negedge clk);
      chk("midreset_no_release", n_rel - nr, 0);
      rst_n = 1'b1;
      t0 = cyc + 1;
      drive(1'b1, 30);
      chk("post_reset_press", last_press - t0, LAT);
      drive(1'b0, 30);

      repeat (40) drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 40)));
      drive(1'b0, 40);
      chk("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
